// File: rtl/ca_field_record_gen_if.sv
// Record stream from the CA field-record generator to its consumer (scoreboard).
// CA_REC_TIMESTAMP_EN adds the rec_ts field to the stream.
interface ca_field_record_gen_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [9:0]  rec_ca;
  logic        rec_cs_n;
  logic [2:0]  rec_cid;
  logic [5:0]  rec_bcw;
  logic [7:0]  rec_dca;
`ifdef CA_REC_TIMESTAMP_EN
  logic [31:0] rec_ts;
`endif

  modport master (
    input  rec_ready,
`ifdef CA_REC_TIMESTAMP_EN
    output rec_ts,
`endif
    output rec_valid, rec_ca, rec_cs_n, rec_cid, rec_bcw, rec_dca
  );

  modport slave (
    output rec_ready,
`ifdef CA_REC_TIMESTAMP_EN
    input  rec_ts,
`endif
    input  rec_valid, rec_ca, rec_cs_n, rec_cid, rec_bcw, rec_dca
  );
endinterface

// File: rtl/ca_field_record_gen.sv
// Taps the host-side DCS_n/DCA bus, assembles 1-UI/2-UI commands into field records
// and queues them for the scoreboard. Optional feature macro: CA_REC_TIMESTAMP_EN.
module ca_field_record_gen #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [1:0]                    dcs_n_in,
  input  logic [6:0]                    dca_in,
  ca_field_record_gen_if.master         rec,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [CNT_W-1:0]              proto_err_cnt,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [9:0]  ca;
    logic        cs_n;
    logic [2:0]  cid;
    logic [5:0]  bcw;
    logic [7:0]  dca;
`ifdef CA_REC_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } rec_t;

  typedef enum logic {S_IDLE, S_UI1} state_e;

  state_e      state_q, state_d;
  logic [6:0]  ui0_q, ui0_d;
  logic        cs_q, cs_d;
`ifdef CA_REC_TIMESTAMP_EN
  logic [31:0] ts_q, ts0_q, ts0_d, r_ts;
`endif

  logic        push_vld, abort;
  logic [6:0]  r_ui0, r_ui1;
  logic        r_cs;
  rec_t        push_rec;

  // Command capture: a UI1 cycle that sees a new DCS_n assertion restarts as UI0.
  always_comb begin
    state_d  = state_q;
    ui0_d    = ui0_q;
    cs_d     = cs_q;
    push_vld = 1'b0;
    abort    = 1'b0;
    r_ui0    = dca_in;
    r_ui1    = '0;
    r_cs     = dcs_n_in[0];
`ifdef CA_REC_TIMESTAMP_EN
    ts0_d    = ts0_q;
    r_ts     = ts_q;
`endif
    if (!en) begin
      state_d = S_IDLE;
    end else if (state_q == S_UI1 && dcs_n_in == 2'b11) begin
      push_vld = 1'b1;
      r_ui0    = ui0_q;
      r_ui1    = dca_in;
      r_cs     = cs_q;
      state_d  = S_IDLE;
`ifdef CA_REC_TIMESTAMP_EN
      r_ts     = ts0_q;
`endif
    end else if (dcs_n_in != 2'b11) begin
      abort = (state_q == S_UI1);
      if (dca_in[1]) begin
        push_vld = 1'b1;
        state_d  = S_IDLE;
      end else begin
        state_d  = S_UI1;
        ui0_d    = dca_in;
        cs_d     = dcs_n_in[0];
`ifdef CA_REC_TIMESTAMP_EN
        ts0_d    = ts_q;
`endif
      end
    end
  end

  always_comb begin
    push_rec      = '0;
    push_rec.ca   = {r_ui1[2:0], r_ui0};
    push_rec.cs_n = r_cs;
    push_rec.cid  = r_ui1[5:3];
    push_rec.dca  = {r_ui1[6], r_ui0};
    push_rec.bcw  = (r_ui0[4:0] == 5'b00101) ? r_ui0[5:0] : 6'd0;
`ifdef CA_REC_TIMESTAMP_EN
    push_rec.ts   = r_ts;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ui0_q   <= '0;
      cs_q    <= 1'b0;
`ifdef CA_REC_TIMESTAMP_EN
      ts_q    <= '0;
      ts0_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ui0_q   <= ui0_d;
      cs_q    <= cs_d;
`ifdef CA_REC_TIMESTAMP_EN
      ts_q    <= ts_q + 32'd1;
      ts0_q   <= ts0_d;
`endif
    end
  end

  // Record FIFO; the output register always mirrors the entry at the read pointer.
  rec_t          mem [FIFO_DEPTH];
  rec_t          out_q, head_d;
  logic          vld_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          pop, full, push_ok, drop;
  logic [CNT_W-1:0] drop_cnt_q, perr_cnt_q;
  logic          ovf_q;

  assign pop      = vld_q && rec.rec_ready;
  assign full     = (cnt_q == LW'(FIFO_DEPTH));
  assign push_ok  = push_vld && (!full || pop);
  assign drop     = push_vld && full && !pop;
  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + LW'(1);
    else if (!push_ok && pop) cnt_d = cnt_q - LW'(1);
  end

  // Bypass when the record being written lands directly at the new head.
  assign head_d = (push_ok && wr_ptr_q == rd_ptr_d) ? push_rec : mem[rd_ptr_d];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      out_q      <= '0;
      drop_cnt_q <= '0;
      perr_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= (cnt_d != '0);
      if (cnt_d != '0) out_q <= head_d;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
      if (abort && perr_cnt_q != '1) perr_cnt_q <= perr_cnt_q + CNT_W'(1);
    end
  end

  assign rec.rec_valid = vld_q;
  assign rec.rec_ca    = out_q.ca;
  assign rec.rec_cs_n  = out_q.cs_n;
  assign rec.rec_cid   = out_q.cid;
  assign rec.rec_bcw   = out_q.bcw;
  assign rec.rec_dca   = out_q.dca;
`ifdef CA_REC_TIMESTAMP_EN
  assign rec.rec_ts    = out_q.ts;
`endif
  assign fifo_level    = cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign proto_err_cnt = perr_cnt_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_ca_field_record_gen.sv
// Bench for ca_field_record_gen: directed scenarios plus randomized traffic against a queue model.
module tb_ca_field_record_gen;
  localparam int D     = 8;
  localparam int CNT_W = 2;  // narrow so counter saturation is reachable
  localparam int LW    = $clog2(D) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [9:0] ca;
    logic       cs_n;
    logic [2:0] cid;
    logic [5:0] bcw;
    logic [7:0] dca;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n, en;
  logic [1:0] dcs_n_in;
  logic [6:0] dca_in;
  logic [LW-1:0] fifo_level;
  logic [CNT_W-1:0] drop_cnt, proto_err_cnt;
  logic overflow;

  ca_field_record_gen_if rif ();

  ca_field_record_gen #(.FIFO_DEPTH(D), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dcs_n_in(dcs_n_in), .dca_in(dca_in),
    .rec(rif), .fifo_level(fifo_level), .drop_cnt(drop_cnt),
    .proto_err_cnt(proto_err_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model state
  rec_t acc_q[$];   // every record the FIFO accepted, in order
  rec_t obs_q[$];   // every record the consumer took
  int   m_level, m_drop, m_perr, m_ovf;
  bit   m_pend;
  int   m_ui0, m_cs;
  int   stall_viol = 0;

  function automatic rec_t mk(int ui0, int ui1, int cs);
    rec_t r;
    r.ca   = 10'((ui1 % 8) * 128 + ui0);
    r.cid  = 3'((ui1 / 8) % 8);
    r.dca  = 8'((ui1 / 64) * 128 + ui0);
    r.bcw  = (ui0 % 32 == 5) ? 6'(ui0 % 64) : 6'd0;
    r.cs_n = 1'(cs);
    return r;
  endfunction

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_level = 0; m_drop = 0; m_perr = 0; m_ovf = 0; m_pend = 0;
    acc_q.delete(); obs_q.delete();
  endtask

  // One bus cycle: drive inputs, advance the model, cross the clock edge.
  task automatic step(input bit e, input bit [1:0] dcs, input bit [6:0] dca, input bit rdy);
    bit pop, push;
    rec_t r;
    en = e; dcs_n_in = dcs; dca_in = dca; rif.rec_ready = rdy;
    pop  = (m_level > 0) && rdy;
    push = 0;
    r    = '0;
    if (!e) m_pend = 0;
    else if (m_pend && dcs == 2'b11) begin
      r = mk(m_ui0, int'(dca), m_cs); push = 1; m_pend = 0;
    end else if (dcs != 2'b11) begin
      if (m_pend) m_perr = sat(m_perr + 1);
      m_pend = 0;
      if (dca[1]) begin
        r = mk(int'(dca), 0, int'(dcs[0])); push = 1;
      end else begin
        m_pend = 1; m_ui0 = int'(dca); m_cs = int'(dcs[0]);
      end
    end
    if (push) begin
      if (m_level < D || pop) begin acc_q.push_back(r); m_level++; end
      else begin m_drop = sat(m_drop + 1); m_ovf = 1; end
    end
    if (pop) m_level--;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * D + 4 && m_level > 0; i++) step(0, 2'b11, 7'h0, 1);
    step(0, 2'b11, 7'h0, 1);
  endtask

  // Consumer-side monitor: collect delivered records and watch stall stability.
  bit   stall_q = 0;
  rec_t prev_rec;
  always @(negedge clk) begin
    rec_t cur;
    cur.ca = rif.rec_ca; cur.cs_n = rif.rec_cs_n; cur.cid = rif.rec_cid;
    cur.bcw = rif.rec_bcw; cur.dca = rif.rec_dca;
    if (!rst_n) stall_q = 0;
    else begin
      if (stall_q && (cur !== prev_rec || rif.rec_valid !== 1'b1)) stall_viol++;
      if (rif.rec_valid === 1'b1 && rif.rec_ready === 1'b1) obs_q.push_back(cur);
      stall_q  = (rif.rec_valid === 1'b1) && !rif.rec_ready;
      prev_rec = cur;
    end
  end

  task automatic test_reset();
    rst_n = 0; en = 0; dcs_n_in = 2'b11; dca_in = '0; rif.rec_ready = 0;
    model_reset();
    repeat (2) @(posedge clk); #1;
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", rif.rec_valid); end
    checks++; if ({rif.rec_ca, rif.rec_cs_n, rif.rec_cid, rif.rec_bcw, rif.rec_dca} !== 28'h0) begin
      errors++; $display("FAIL reset_fields: got %0h exp 0", {rif.rec_ca, rif.rec_cs_n, rif.rec_cid, rif.rec_bcw, rif.rec_dca}); end
    checks++; if (fifo_level !== '0 || drop_cnt !== '0 || proto_err_cnt !== '0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_status: got lvl=%0d drop=%0d perr=%0d ovf=%0b exp all 0", fifo_level, drop_cnt, proto_err_cnt, overflow); end
    rst_n = 1;
    step(0, 2'b11, 7'h0, 0);
  endtask

  task automatic test_two_ui();
    step(1, 2'b10, 7'h05, 0);
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL two_ui_early: got valid=%0b exp 0", rif.rec_valid); end
    step(1, 2'b11, 7'h6A, 0);
    // ui0=0x05, ui1=0x6A: ca={3'b010,7'h05}, cid=3'b101, dca={1,7'h05}, bcw=ui0[5:0]
    checks++; if (rif.rec_valid !== 1'b1) begin errors++; $display("FAIL two_ui_latency: got valid=%0b exp 1", rif.rec_valid); end
    checks++; if (rif.rec_ca !== 10'h105 || rif.rec_cid !== 3'd5 || rif.rec_dca !== 8'h85 ||
                  rif.rec_bcw !== 6'h05 || rif.rec_cs_n !== 1'b0) begin
      errors++; $display("FAIL two_ui_fields: got ca=%0h cid=%0d dca=%0h bcw=%0h cs=%0b exp ca=105 cid=5 dca=85 bcw=5 cs=0",
                         rif.rec_ca, rif.rec_cid, rif.rec_dca, rif.rec_bcw, rif.rec_cs_n); end
    step(0, 2'b11, 7'h0, 0);
    checks++; if (rif.rec_ca !== 10'h105 || rif.rec_valid !== 1'b1) begin
      errors++; $display("FAIL two_ui_hold: got ca=%0h valid=%0b exp 105/1", rif.rec_ca, rif.rec_valid); end
    drain();
    checks++; if (obs_q.size() !== 1 || acc_q.size() !== 1 || obs_q[0] !== acc_q[0]) begin
      errors++; $display("FAIL two_ui_delivery: got %0d records exp 1", obs_q.size()); end
    acc_q.delete(); obs_q.delete();
  endtask

  task automatic test_one_ui_b2b();
    step(1, 2'b01, 7'h12, 1);
    checks++; if (rif.rec_valid !== 1'b1 || rif.rec_ca !== 10'h012 || rif.rec_cid !== 3'd0 ||
                  rif.rec_cs_n !== 1'b1 || rif.rec_dca !== 8'h12 || rif.rec_bcw !== 6'd0) begin
      errors++; $display("FAIL one_ui_fields: got v=%0b ca=%0h cid=%0d cs=%0b dca=%0h bcw=%0h exp 1/012/0/1/12/0",
                         rif.rec_valid, rif.rec_ca, rif.rec_cid, rif.rec_cs_n, rif.rec_dca, rif.rec_bcw); end
    for (int i = 0; i < 8; i++) begin
      step(1, 2'($urandom_range(0, 2)), 7'($urandom) | 7'h02, 1);
      checks++; if (rif.rec_valid !== 1'b1 || fifo_level !== LW'(1)) begin
        errors++; $display("FAIL one_ui_rate: got valid=%0b level=%0d exp 1/1 at %0d", rif.rec_valid, fifo_level, i); end
    end
    drain();
    checks++; if (obs_q.size() !== 9 || acc_q.size() !== 9) begin
      errors++; $display("FAIL one_ui_count: got %0d exp 9", obs_q.size()); end
    else foreach (acc_q[i]) begin
      checks++; if (obs_q[i] !== acc_q[i]) begin errors++; $display("FAIL one_ui_rec: got %0h exp %0h at %0d", obs_q[i], acc_q[i], i); end
    end
    acc_q.delete(); obs_q.delete();
  endtask

  task automatic test_abort();
    step(1, 2'b10, 7'h05, 1);
    step(1, 2'b10, 7'h44, 1);
    step(1, 2'b11, 7'($urandom), 1);
    checks++; if (proto_err_cnt !== CNT_W'(m_perr) || m_perr != 1) begin
      errors++; $display("FAIL abort_perr: got %0d exp 1", proto_err_cnt); end
    drain();
    checks++; if (obs_q.size() !== 1 || acc_q.size() !== 1 || obs_q[0] !== acc_q[0]) begin
      errors++; $display("FAIL abort_records: got %0d records exp 1", obs_q.size()); end
    acc_q.delete(); obs_q.delete();
  endtask

  task automatic test_en_mid();
    step(1, 2'b10, 7'h05, 1);
    step(0, 2'b11, 7'h6A, 1);
    step(1, 2'b11, 7'h11, 1);
    checks++; if (rif.rec_valid !== 1'b0 || proto_err_cnt !== CNT_W'(m_perr)) begin
      errors++; $display("FAIL en_mid_discard: got valid=%0b perr=%0d exp 0/%0d", rif.rec_valid, proto_err_cnt, m_perr); end
    step(1, 2'b01, 7'h21, 1);
    step(1, 2'b11, 7'h3C, 1);
    drain();
    checks++; if (obs_q.size() !== 1 || acc_q.size() !== 1 || obs_q[0] !== acc_q[0]) begin
      errors++; $display("FAIL en_mid_next: got %0d records exp 1", obs_q.size()); end
    acc_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D + 3; i++) step(1, 2'b01, 7'($urandom) | 7'h02, 0);
    checks++; if (fifo_level !== LW'(D) || drop_cnt !== CNT_W'(3) || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_fill: got lvl=%0d drop=%0d ovf=%0b exp 8/3/1", fifo_level, drop_cnt, overflow); end
    step(1, 2'b10, 7'($urandom) | 7'h02, 1);
    checks++; if (fifo_level !== LW'(D) || drop_cnt !== CNT_W'(3)) begin
      errors++; $display("FAIL overflow_push_pop: got lvl=%0d drop=%0d exp 8/3", fifo_level, drop_cnt); end
    step(1, 2'b01, 7'h02, 0);
    step(1, 2'b01, 7'h03, 0);
    checks++; if (drop_cnt !== CNT_W'(CMAX) || drop_cnt !== CNT_W'(m_drop)) begin
      errors++; $display("FAIL drop_saturate: got %0d exp %0d", drop_cnt, CMAX); end
    drain();
    checks++; if (obs_q.size() !== D + 1 || acc_q.size() !== D + 1) begin
      errors++; $display("FAIL overflow_count: got %0d exp %0d", obs_q.size(), D + 1); end
    else foreach (acc_q[i]) begin
      checks++; if (obs_q[i] !== acc_q[i]) begin errors++; $display("FAIL overflow_rec: got %0h exp %0h at %0d", obs_q[i], acc_q[i], i); end
    end
    acc_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    step(1, 2'b10, 7'h05, 1);
    rst_n = 0;
    model_reset();
    #2;
    checks++; if (drop_cnt !== '0 || proto_err_cnt !== '0 || overflow !== 1'b0 || fifo_level !== '0 || rif.rec_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_clear: got drop=%0d perr=%0d ovf=%0b lvl=%0d v=%0b exp 0",
                         drop_cnt, proto_err_cnt, overflow, fifo_level, rif.rec_valid); end
    #1 rst_n = 1;
    en = 0; dcs_n_in = 2'b11;
    @(posedge clk); #1;
    step(1, 2'b11, 7'h6A, 1);
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_stale: got valid=%0b exp 0", rif.rec_valid); end
    step(1, 2'b10, 7'h05, 1);
    step(1, 2'b11, 7'h6A, 1);
    drain();
    checks++; if (obs_q.size() !== 1 || acc_q.size() !== 1 || obs_q[0] !== acc_q[0] || proto_err_cnt !== '0) begin
      errors++; $display("FAIL reset_mid_next: got %0d records perr=%0d exp 1/0", obs_q.size(), proto_err_cnt); end
    acc_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    int cmds = 0;
    stall_viol = 0;
    for (int i = 0; i < 2000 && cmds < 100; i++) begin
      bit e; bit [1:0] dcs;
      e   = ($urandom_range(0, 19) != 0);
      dcs = ($urandom_range(0, 9) < 5) ? 2'b11 : 2'($urandom_range(0, 2));
      if (e && dcs != 2'b11) cmds++;
      step(e, dcs, 7'($urandom), ($urandom_range(0, 3) != 0));
    end
    checks++; if (fifo_level !== LW'(m_level)) begin errors++; $display("FAIL bp_level: got %0d exp %0d", fifo_level, m_level); end
    checks++; if (drop_cnt !== CNT_W'(m_drop) || overflow !== 1'(m_ovf)) begin
      errors++; $display("FAIL bp_drop: got drop=%0d ovf=%0b exp %0d/%0d", drop_cnt, overflow, m_drop, m_ovf); end
    checks++; if (proto_err_cnt !== CNT_W'(m_perr)) begin errors++; $display("FAIL bp_perr: got %0d exp %0d", proto_err_cnt, m_perr); end
    drain();
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes exp 0", stall_viol); end
    checks++; if (obs_q.size() !== acc_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d exp %0d", obs_q.size(), acc_q.size()); end
    else foreach (acc_q[i]) begin
      if (obs_q[i] !== acc_q[i]) begin
        checks++; errors++; $display("FAIL bp_rec: got %0h exp %0h at %0d", obs_q[i], acc_q[i], i);
      end
    end
    acc_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_two_ui();
    test_one_ui_b2b();
    test_abort();
    test_en_mid();
    test_overflow();
    test_reset_mid();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish exp finish within 500000");
    $fatal(1);
  end
endmodule
